uart_echo_client: RTL and testbench

Host-side client of the UART core's receive (STP) and transmit (DRP) ports. It takes received 10-bit status/data words, counts parity, frame and overflow errors, and buffers the received bytes in a FIFO. It then hands each byte back to the transmitter through the DRP ready/strobe handshake, giving a loopback echo. It sits directly above the UART core and is the logic at the other end of both its STP and DRP interfaces.

---
 rtl/uart_echo_if.sv | 24 ++
 rtl/uart_echo_client.sv | 107 ++++++++++
 tb/tb_uart_echo_client.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_echo_if.sv
// STP/DRP-side signal bundle between the UART core side (master) and the echo client (slave).
// FIFO_AW must match the client's FIFO_AW so that FIFO_LVL widths agree.
interface uart_echo_if #(parameter int FIFO_AW = 4);
    logic             RX_DATA_EN;
    logic [9:0]       RX_DATA_T;
    logic             TX_RDY_R;
    logic             TX_RDY_T;
    logic [7:0]       TX_DATA_R;
    logic             CLR_CNT;
    logic [7:0]       PAR_ERR_CNT;
    logic [7:0]       FRM_ERR_CNT;
    logic [7:0]       OVF_CNT;
    logic [FIFO_AW:0] FIFO_LVL;

    modport master (
        output RX_DATA_EN, RX_DATA_T, TX_RDY_R, CLR_CNT,
        input  TX_RDY_T, TX_DATA_R, PAR_ERR_CNT, FRM_ERR_CNT, OVF_CNT, FIFO_LVL
    );

    modport slave (
        input  RX_DATA_EN, RX_DATA_T, TX_RDY_R, CLR_CNT,
        output TX_RDY_T, TX_DATA_R, PAR_ERR_CNT, FRM_ERR_CNT, OVF_CNT, FIFO_LVL
    );
endinterface

// File: rtl/uart_echo_client.sv
// UART loopback client: counts parity/frame/overflow errors, buffers bytes, echoes them via DRP.
// Latency: strobe issued one edge after the write edge; UART_ECHO_DROP_BAD_EN drops error words.
// Backpressure: transmit waits on TX_RDY_R low-then-high; receive never stalls, full FIFO drops bytes.
module uart_echo_client #(
    parameter int FIFO_AW = 4
) (
    input logic       CLK,
    input logic       RST,
    uart_echo_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {T_IDLE, T_WLOW, T_WHIGH} t_state_e;

    t_state_e         state, state_nxt;
    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, lvl;
    logic             fifo_full, fifo_empty;
    logic             wr_accept, wr_en, pop;
    logic             tx_rdy_t;
    logic [7:0]       tx_data_r;
    logic [7:0]       par_cnt, frm_cnt, ovf_cnt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        return (inc && v != 8'hFF) ? v + 8'd1 : v;
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

`ifdef UART_ECHO_DROP_BAD_EN
    assign wr_accept = bus.RX_DATA_EN && !(bus.RX_DATA_T[8] || bus.RX_DATA_T[9]);
`else
    assign wr_accept = bus.RX_DATA_EN;
`endif
    // Full is judged before a same-cycle pop frees a slot.
    assign wr_en = wr_accept && !fifo_full;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            T_IDLE: begin
                if (!fifo_empty && bus.TX_RDY_R) begin
                    pop       = 1'b1;
                    state_nxt = T_WLOW;
                end
            end
            T_WLOW:  if (!bus.TX_RDY_R) state_nxt = T_WHIGH;
            T_WHIGH: if (bus.TX_RDY_R)  state_nxt = T_IDLE;
            default: state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= T_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lvl       <= '0;
            tx_rdy_t  <= 1'b0;
            tx_data_r <= 8'h00;
        end else begin
            state    <= state_nxt;
            tx_rdy_t <= pop;
            if (pop) begin
                tx_data_r <= mem[rd_ptr[FIFO_AW-1:0]];
                rd_ptr    <= rd_ptr + PTR_ONE;
            end
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            unique case ({wr_en, pop})
                2'b10:   lvl <= lvl + PTR_ONE;
                2'b01:   lvl <= lvl - PTR_ONE;
                default: lvl <= lvl;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= bus.RX_DATA_T[7:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_cnt <= 8'h00;
            frm_cnt <= 8'h00;
            ovf_cnt <= 8'h00;
        end else if (bus.CLR_CNT) begin
            par_cnt <= 8'h00;
            frm_cnt <= 8'h00;
            ovf_cnt <= 8'h00;
        end else begin
            par_cnt <= sat_inc(par_cnt, bus.RX_DATA_EN && bus.RX_DATA_T[8]);
            frm_cnt <= sat_inc(frm_cnt, bus.RX_DATA_EN && bus.RX_DATA_T[9]);
            ovf_cnt <= sat_inc(ovf_cnt, wr_accept && fifo_full);
        end
    end

    assign bus.TX_RDY_T    = tx_rdy_t;
    assign bus.TX_DATA_R   = tx_data_r;
    assign bus.PAR_ERR_CNT = par_cnt;
    assign bus.FRM_ERR_CNT = frm_cnt;
    assign bus.OVF_CNT     = ovf_cnt;
    assign bus.FIFO_LVL    = lvl;
endmodule

// File: tb/tb_uart_echo_client.sv
// Directed bench for uart_echo_client: inputs driven and outputs sampled on the falling edge.
module tb_uart_echo_client;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    uart_echo_if #(.FIFO_AW(AW)) bus ();

    uart_echo_client #(.FIFO_AW(AW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rx_word(input logic [9:0] w);
        bus.RX_DATA_EN = 1'b1;
        bus.RX_DATA_T  = w;
        tick();
        bus.RX_DATA_EN = 1'b0;
    endtask

    task automatic finish_xfer();
        bus.TX_RDY_R = 1'b0;
        tick();
        tick();
        bus.TX_RDY_R = 1'b1;
        tick();
    endtask

    task automatic xmit_one(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        bus.TX_RDY_R = 1'b1;
        while (bus.TX_RDY_T !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_strobe"}, 32'(bus.TX_RDY_T), 32'd1);
        chk({tag, "_data"}, 32'(bus.TX_DATA_R), 32'(exp));
        tick();
        chk({tag, "_width"}, 32'(bus.TX_RDY_T), 32'd0);
        finish_xfer();
    endtask

    initial begin
        logic seen;
        bus.RX_DATA_EN = 1'b0;
        bus.RX_DATA_T  = 10'h000;
        bus.TX_RDY_R   = 1'b1;
        bus.CLR_CNT    = 1'b0;
        tick();
        tick();
        chk("rst_tx_rdy_t", 32'(bus.TX_RDY_T), 32'd0);
        chk("rst_tx_data",  32'(bus.TX_DATA_R), 32'h00);
        chk("rst_par",      32'(bus.PAR_ERR_CNT), 32'd0);
        chk("rst_frm",      32'(bus.FRM_ERR_CNT), 32'd0);
        chk("rst_ovf",      32'(bus.OVF_CNT), 32'd0);
        chk("rst_lvl",      32'(bus.FIFO_LVL), 32'd0);
        rst = 1'b0;
        tick();

        // Single echo: strobe lands in the cycle after the edge following the write.
        rx_word(10'h041);
        chk("echo_lvl1", 32'(bus.FIFO_LVL), 32'd1);
        chk("echo_early", 32'(bus.TX_RDY_T), 32'd0);
        tick();
        chk("echo_strobe", 32'(bus.TX_RDY_T), 32'd1);
        chk("echo_data", 32'(bus.TX_DATA_R), 32'h41);
        chk("echo_lvl0", 32'(bus.FIFO_LVL), 32'd0);
        tick();
        chk("echo_width", 32'(bus.TX_RDY_T), 32'd0);
        finish_xfer();
        chk("echo_par", 32'(bus.PAR_ERR_CNT), 32'd0);
        chk("echo_frm", 32'(bus.FRM_ERR_CNT), 32'd0);
        chk("echo_ovf", 32'(bus.OVF_CNT), 32'd0);

        // Error words, held in the FIFO while the transmitter is busy.
        bus.TX_RDY_R = 1'b0;
        rx_word(10'h155);
        rx_word(10'h2AA);
        rx_word(10'h3FF);
        chk("err_par", 32'(bus.PAR_ERR_CNT), 32'd2);
        chk("err_frm", 32'(bus.FRM_ERR_CNT), 32'd2);
`ifdef UART_ECHO_DROP_BAD_EN
        chk("err_lvl", 32'(bus.FIFO_LVL), 32'd0);
        bus.TX_RDY_R = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (bus.TX_RDY_T === 1'b1) seen = 1'b1;
        end
        chk("err_no_echo", 32'(seen), 32'd0);
`else
        chk("err_lvl", 32'(bus.FIFO_LVL), 32'd3);
        xmit_one("err_55", 8'h55);
        xmit_one("err_aa", 8'hAA);
        xmit_one("err_ff", 8'hFF);
`endif
        chk("err_ovf", 32'(bus.OVF_CNT), 32'd0);

        // Overflow: 18 good bytes into a 16-deep FIFO, then drain in order.
        bus.TX_RDY_R = 1'b0;
        for (int i = 1; i <= 18; i++) rx_word(10'(i));
        chk("ovf_lvl", 32'(bus.FIFO_LVL), 32'd16);
        chk("ovf_cnt", 32'(bus.OVF_CNT), 32'd2);
        for (int i = 1; i <= 16; i++) xmit_one("ovf_drain", 8'(i));
        chk("ovf_lvl_empty", 32'(bus.FIFO_LVL), 32'd0);

        // Write and pop on the same edge.
        bus.TX_RDY_R = 1'b0;
        rx_word(10'h0A1);
        rx_word(10'h0A2);
        rx_word(10'h0A3);
        chk("wp_lvl_pre", 32'(bus.FIFO_LVL), 32'd3);
        bus.TX_RDY_R   = 1'b1;
        bus.RX_DATA_EN = 1'b1;
        bus.RX_DATA_T  = 10'h0A4;
        tick();
        bus.RX_DATA_EN = 1'b0;
        chk("wp_lvl_same", 32'(bus.FIFO_LVL), 32'd3);
        chk("wp_strobe", 32'(bus.TX_RDY_T), 32'd1);
        chk("wp_data_a1", 32'(bus.TX_DATA_R), 32'hA1);
        tick();
        chk("wp_width", 32'(bus.TX_RDY_T), 32'd0);
        finish_xfer();
        xmit_one("wp_a2", 8'hA2);
        xmit_one("wp_a3", 8'hA3);
        xmit_one("wp_a4", 8'hA4);

        // Saturation and clear priority.
        bus.TX_RDY_R = 1'b0;
        bus.CLR_CNT  = 1'b1;
        tick();
        bus.CLR_CNT  = 1'b0;
        chk("clr_par", 32'(bus.PAR_ERR_CNT), 32'd0);
        chk("clr_frm", 32'(bus.FRM_ERR_CNT), 32'd0);
        chk("clr_ovf", 32'(bus.OVF_CNT), 32'd0);
        repeat (300) rx_word(10'h100);
        chk("sat_par", 32'(bus.PAR_ERR_CNT), 32'd255);
        chk("sat_frm", 32'(bus.FRM_ERR_CNT), 32'd0);
`ifdef UART_ECHO_DROP_BAD_EN
        chk("sat_ovf", 32'(bus.OVF_CNT), 32'd0);
        chk("sat_lvl", 32'(bus.FIFO_LVL), 32'd0);
`else
        chk("sat_ovf", 32'(bus.OVF_CNT), 32'd255);
        chk("sat_lvl", 32'(bus.FIFO_LVL), 32'd16);
`endif
        bus.CLR_CNT    = 1'b1;
        bus.RX_DATA_EN = 1'b1;
        bus.RX_DATA_T  = 10'h300;
        tick();
        bus.CLR_CNT    = 1'b0;
        bus.RX_DATA_EN = 1'b0;
        chk("clrpri_par", 32'(bus.PAR_ERR_CNT), 32'd0);
        chk("clrpri_frm", 32'(bus.FRM_ERR_CNT), 32'd0);
        chk("clrpri_ovf", 32'(bus.OVF_CNT), 32'd0);

        // Reset while waiting for TX_RDY_R low, with five bytes still queued.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus.TX_RDY_R = 1'b0;
`ifdef UART_ECHO_DROP_BAD_EN
        for (int i = 0; i < 6; i++) rx_word(10'h010 + 10'(i));
`else
        for (int i = 0; i < 5; i++) rx_word(10'h010 + 10'(i));
`endif
        rx_word(10'h1C0);
        chk("mid_lvl6", 32'(bus.FIFO_LVL), 32'd6);
        chk("mid_par1", 32'(bus.PAR_ERR_CNT), 32'd1);
        bus.TX_RDY_R = 1'b1;
        tick();
        chk("mid_strobe", 32'(bus.TX_RDY_T), 32'd1);
        chk("mid_lvl5", 32'(bus.FIFO_LVL), 32'd5);
        rst = 1'b1;
        #1;
        chk("mid_rst_strobe", 32'(bus.TX_RDY_T), 32'd0);
        chk("mid_rst_lvl", 32'(bus.FIFO_LVL), 32'd0);
        chk("mid_rst_par", 32'(bus.PAR_ERR_CNT), 32'd0);
        chk("mid_rst_data", 32'(bus.TX_DATA_R), 32'h00);
        tick();
        rst = 1'b0;
        tick();
        rx_word(10'h05A);
        chk("post_rst_lvl", 32'(bus.FIFO_LVL), 32'd1);
        xmit_one("post_rst", 8'h5A);
        chk("post_rst_empty", 32'(bus.FIFO_LVL), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
